// File: rtl/sobel_grad.sv
// rtl/sobel_grad.sv - 3x3 Sobel gradient with L1 magnitude and 2-bit direction
// Define SOBEL_MAXMIN_MAG_EN for the max+min/2 magnitude approximation.
module sobel_grad #(
    parameter int IMG_W = 1026,
    parameter int MAG_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       state,
    input  logic             pix_en,
    input  logic [7:0]       pix_in,
    output logic             grad_valid,
    output logic [MAG_W-1:0] grad_mag,
    output logic [1:0]       grad_dir,
    output logic             grad_edg,
    output logic             line_start
);

    localparam int COL_W = $clog2(IMG_W);
    localparam logic [3:0] ST_DONE = 4'b1000;

    logic [7:0]       line_a [IMG_W];
    logic [7:0]       line_b [IMG_W];
    logic [7:0]       rd_a, rd_b;
    logic             accept;
    logic [COL_W-1:0] col_q, col_d;
    logic [1:0]       row_q, row_d;

    logic [7:0]       win_q [3][3];
    logic             v1_q, e1_q, ls1_q;

    logic [10:0]      gx_pos, gx_neg, gy_pos, gy_neg;
    logic [10:0]      gx, gy, ax, ay, mag_s3;

    logic             v3_q, e3_q, ls3_q, seq3_q;
    logic [10:0]      ax3_q, ay3_q;
    logic [MAG_W-1:0] mag3_q;

    logic [18:0]      ax_tan, ay_tan, ax_sh, ay_sh;
    logic [1:0]       dir_s4;

    logic             valid_q, edg_q, ls_q;
    logic [MAG_W-1:0] mag_q;
    logic [1:0]       dir_q;

    assign accept = pix_en && (state != ST_DONE);
    assign rd_a   = line_a[col_q];
    assign rd_b   = line_b[col_q];

    // Reads above happen before this edge's write, so both buffers see old data.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_a[col_q] <= pix_in;
            line_b[col_q] <= rd_a;
        end
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (state == ST_DONE) begin
            col_d = '0;
            row_d = '0;
        end else if (accept) begin
            if (col_q == COL_W'(IMG_W - 1)) begin
                col_d = '0;
                if (row_q != 2'd2) row_d = row_q + 2'd1;
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // S1: counters and window shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
            v1_q  <= 1'b0;
            e1_q  <= 1'b0;
            ls1_q <= 1'b0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win_q[r][c] <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            v1_q  <= accept && (row_q == 2'd2);
            if (accept) begin
                e1_q  <= col_q < COL_W'(2);
                ls1_q <= col_q == '0;
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= rd_b;
                win_q[1][2] <= rd_a;
                win_q[2][2] <= pix_in;
            end
        end
    end

    // S2 (combinational from the window) and S3 abs / magnitude
    always_comb begin
        gx_pos = 11'(win_q[0][2]) + {2'b0, win_q[1][2], 1'b0} + 11'(win_q[2][2]);
        gx_neg = 11'(win_q[0][0]) + {2'b0, win_q[1][0], 1'b0} + 11'(win_q[2][0]);
        gy_pos = 11'(win_q[2][0]) + {2'b0, win_q[2][1], 1'b0} + 11'(win_q[2][2]);
        gy_neg = 11'(win_q[0][0]) + {2'b0, win_q[0][1], 1'b0} + 11'(win_q[0][2]);
        gx     = gx_pos - gx_neg;
        gy     = gy_pos - gy_neg;
        ax     = gx[10] ? (11'd0 - gx) : gx;
        ay     = gy[10] ? (11'd0 - gy) : gy;
`ifdef SOBEL_MAXMIN_MAG_EN
        mag_s3 = (ax >= ay) ? (ax + (ay >> 1)) : (ay + (ax >> 1));
`else
        mag_s3 = ax + ay;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_q   <= 1'b0;
            e3_q   <= 1'b0;
            ls3_q  <= 1'b0;
            seq3_q <= 1'b0;
            ax3_q  <= '0;
            ay3_q  <= '0;
            mag3_q <= '0;
        end else begin
            v3_q   <= v1_q;
            e3_q   <= e1_q;
            ls3_q  <= ls1_q;
            seq3_q <= gx[10] == gy[10];
            ax3_q  <= ax;
            ay3_q  <= ay;
            mag3_q <= MAG_W'(mag_s3);
        end
    end

    // S4: direction sectors using tan(22.5 deg) ~= 106/256
    always_comb begin
        ax_tan = {8'b0, ax3_q} * 19'd106;
        ay_tan = {8'b0, ay3_q} * 19'd106;
        ax_sh  = {ax3_q, 8'b0};
        ay_sh  = {ay3_q, 8'b0};
        if (ay_sh <= ax_tan)      dir_s4 = 2'd0;
        else if (ax_sh <= ay_tan) dir_s4 = 2'd2;
        else if (seq3_q)          dir_s4 = 2'd1;
        else                      dir_s4 = 2'd3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            mag_q   <= '0;
            dir_q   <= '0;
            edg_q   <= 1'b0;
            ls_q    <= 1'b0;
        end else begin
            valid_q <= v3_q;
            mag_q   <= (v3_q && !e3_q) ? mag3_q : '0;
            dir_q   <= (v3_q && !e3_q) ? dir_s4 : 2'd0;
            edg_q   <= v3_q && e3_q;
            ls_q    <= v3_q && ls3_q;
        end
    end

    assign grad_valid = valid_q;
    assign grad_mag   = mag_q;
    assign grad_dir   = dir_q;
    assign grad_edg   = edg_q;
    assign line_start = ls_q;

endmodule

// File: tb/tb_sobel_grad.sv
// tb/tb_sobel_grad.sv - scoreboard bench for sobel_grad (IMG_W=8)
module tb_sobel_grad;

    localparam int W     = 8;
    localparam int MAG_W = 11;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       state;
    logic             pix_en;
    logic [7:0]       pix_in;
    logic             grad_valid;
    logic [MAG_W-1:0] grad_mag;
    logic [1:0]       grad_dir;
    logic             grad_edg;
    logic             line_start;

    typedef struct {
        int mag;
        int dir;
        int edg;
        int ls;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   img [0:31][0:W-1];
    int   mrow = 0;
    int   mcol = 0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    sobel_grad #(.IMG_W(W), .MAG_W(MAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .state(state), .pix_en(pix_en), .pix_in(pix_in),
        .grad_valid(grad_valid), .grad_mag(grad_mag), .grad_dir(grad_dir),
        .grad_edg(grad_edg), .line_start(line_start)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic exp_t model(input int r, input int c, input int cy);
        exp_t e;
        int p [3][3];
        int gx, gy, ax, ay;
        e.cyc = cy;
        e.ls  = (c == 0) ? 1 : 0;
        e.edg = (c < 2) ? 1 : 0;
        e.mag = 0;
        e.dir = 0;
        if (c >= 2) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    p[i][j] = img[r-2+i][c-2+j];
            gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
            gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
            ax = (gx < 0) ? -gx : gx;
            ay = (gy < 0) ? -gy : gy;
`ifdef SOBEL_MAXMIN_MAG_EN
            e.mag = (ax >= ay) ? ax + ay/2 : ay + ax/2;
`else
            e.mag = ax + ay;
`endif
            if (ay*256 <= ax*106)      e.dir = 0;
            else if (ax*256 <= ay*106) e.dir = 2;
            else                       e.dir = ((gx < 0) == (gy < 0)) ? 1 : 3;
        end
        return e;
    endfunction

    function automatic int pat(input int p, input int r, input int c);
        case (p)
            0:       return 50;
            1:       return (c < 4) ? 0 : 100;
            2:       return (r < 2) ? 0 : 100;
            3:       return 10*(r + c);
            4:       return 10*(r - c) + 100;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic drive(input logic en, input logic [3:0] st, input int val);
        @(posedge clk);
        #1;
        pix_en = en;
        state  = st;
        pix_in = val[7:0];
        if (st == 4'b1000) begin
            mrow = 0;
            mcol = 0;
        end else if (en) begin
            img[mrow][mcol] = val;
            if (mrow >= 2) sb.push_back(model(mrow, mcol, cyc + 3));
            mcol++;
            if (mcol == W) begin
                mcol = 0;
                mrow++;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        pix_en = 1'b0;
        state  = 4'b0001;
        check("rst_mid_valid", grad_valid, 0);
        check("rst_mid_mag", grad_mag, 0);
        check("rst_mid_dir", grad_dir, 0);
        check("rst_mid_edg", grad_edg, 0);
        check("rst_mid_ls", line_start, 0);
        sb.delete();
        mrow = 0;
        mcol = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic run_frame(input int p, input int nrows, input bit thr, input bit flush,
                             input int rst_row);
        logic [3:0] st;
        int         v;
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < W; c++) begin
                if (rst_row >= 0 && r == rst_row && c == 3) begin
                    do_reset();
                    return;
                end
                st = (flush && r == nrows-1) ? 4'b0100 : ((r % 2 == 1) ? 4'b0010 : 4'b0001);
                v  = (flush && r == nrows-1) ? 0 : pat(p, r, c);
                drive(1'b1, st, v);
                if (thr) drive(1'b0, st, 0);
            end
        end
        drive(1'b1, 4'b1000, 8'hA5);
        drive(1'b1, 4'b1000, 8'h5A);
        repeat (3) drive(1'b0, 4'b1000, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (grad_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check("mag", grad_mag, e.mag);
                check("dir", grad_dir, e.dir);
                check("edg", grad_edg, e.edg);
                check("line_start", line_start, e.ls);
                check("latency", cyc, e.cyc);
            end
        end else begin
            check("idle_zero", int'({grad_mag, grad_dir, grad_edg, line_start}), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        state  = 4'b0001;
        pix_en = 1'b0;
        pix_in = 8'd0;
        #12;
        check("reset_valid", grad_valid, 0);
        check("reset_mag", grad_mag, 0);
        check("reset_dir", grad_dir, 0);
        check("reset_edg", grad_edg, 0);
        check("reset_ls", line_start, 0);
        #10 rst_n = 1'b1;

        run_frame(0, 4, 1'b0, 1'b0, -1);
        run_frame(1, 4, 1'b0, 1'b0, -1);
        run_frame(2, 4, 1'b0, 1'b0, -1);
        run_frame(3, 4, 1'b0, 1'b0, -1);
        run_frame(4, 4, 1'b0, 1'b0, -1);
        run_frame(3, 4, 1'b1, 1'b0, -1);
        run_frame(5, 5, 1'b0, 1'b1, -1);
        run_frame(5, 4, 1'b1, 1'b0, -1);
        run_frame(5, 6, 1'b0, 1'b0, 3);
        run_frame(5, 4, 1'b0, 1'b0, -1);

        repeat (10) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
